// File: rtl/mux_stream_arb_pkg.sv
// mux_stream_arb_pkg: selection-mode constants and reset values shared by the stream mux
package mux_stream_arb_pkg;
  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;
  localparam int MODE_EXT  = 2;
  localparam logic RST_VALID = 1'b0;
endpackage

// File: rtl/mux_stream_arb_arbiter.sv
// rr_arbiter: one-hot grant searching upward from ptr_i+1 with wrap, or pinned to lock_idx_i while locked
module rr_arbiter #(
  parameter int N = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  input  logic            lock_i,
  input  logic [SELW-1:0] lock_idx_i,
  output logic [N-1:0]    grant_o,
  output logic [SELW-1:0] idx_o
);
  int j;
  // Farthest candidate first so the nearest requester after ptr_i is the last write and wins
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    j = 0;
    if (lock_i) begin
      grant_o[lock_idx_i] = req_i[lock_idx_i];
      idx_o = lock_idx_i;
    end else begin
      for (int k = N; k >= 1; k--) begin
        j = (int'(ptr_i) + k) % N;
        if (req_i[j]) begin
          grant_o = '0;
          grant_o[j] = 1'b1;
          idx_o = SELW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-input registered valid/ready stream mux (RR/priority/external select); MUX_STREAM_LOCK_EN adds in_last packet lock
module mux_stream_arb
  import mux_stream_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 8,
  parameter int MODE = MODE_RR,
  localparam int SELW = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
`ifdef MUX_STREAM_LOCK_EN
  input  logic [N-1:0]     in_last,
`endif
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d, gdata;
  logic [SELW-1:0] out_sel_q, out_sel_d, ptr_q, ptr_d, arb_idx, gidx, lock_idx;
  logic out_valid_q, out_valid_d, load, xfer, lock;
  logic [N-1:0] arb_grant, ext_grant, grant;
  assign load = ~out_valid_q | out_ready;
  assign grant = (MODE == MODE_EXT) ? ext_grant : arb_grant;
  assign gidx = (MODE == MODE_EXT) ? sel : arb_idx;
  assign xfer = load & |grant;
  assign in_ready = grant & {N{load & reset_n}};
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
  assign out_valid = out_valid_q;
  rr_arbiter #(.N(N)) u_arb (
    .req_i(in_valid),
    .ptr_i((MODE == MODE_RR) ? ptr_q : SELW'(N - 1)),
    .lock_i(lock),
    .lock_idx_i(lock_idx),
    .grant_o(arb_grant),
    .idx_o(arb_idx)
  );
  // External select: only a valid channel whose index matches sel is granted, so sel >= N grants nothing
  always_comb begin
    ext_grant = '0;
    for (int i = 0; i < N; i++) ext_grant[i] = in_valid[i] & (sel == SELW'(i));
  end
  // AND-OR data select against the one-hot grant
  always_comb begin
    gdata = '0;
    for (int i = 0; i < N; i++) gdata = gdata | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
  end
  // Output register and pointer next state; everything holds while stalled
  always_comb begin
    out_valid_d = load ? |grant : out_valid_q;
    out_data_d = xfer ? gdata : out_data_q;
    out_sel_d = xfer ? gidx : out_sel_q;
    ptr_d = (xfer && MODE == MODE_RR) ? gidx : ptr_q;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= RST_VALID;
      out_data_q <= '0;
      out_sel_q <= '0;
      ptr_q <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef MUX_STREAM_LOCK_EN
  logic lock_q, lock_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;
  assign lock = lock_q;
  assign lock_idx = lock_idx_q;
  // Lock onto the granted channel until its in_last word is accepted
  always_comb begin
    lock_d = (xfer && MODE != MODE_EXT) ? ~in_last[gidx] : lock_q;
    lock_idx_d = xfer ? gidx : lock_idx_q;
  end
  // Lock registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  assign lock = 1'b0;
  assign lock_idx = '0;
`endif
endmodule

// File: tb/tb_mux_stream_arb.sv
// tb_mux_stream_arb: scoreboard bench over MODE 0/1/2 instances of mux_stream_arb
module tb_mux_stream_arb;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  logic [3:0] in_valid = 4'hF;
  logic [1:0] sel = 2'd0;
  logic out_ready = 1'b1;
`ifdef MUX_STREAM_LOCK_EN
  logic [3:0] in_last = 4'h0;
`endif
  logic [2:0][7:0] od;
  logic [2:0][1:0] os;
  logic [2:0] ov;
  logic [2:0][3:0] ir;
  int checks = 0;
  int errors = 0;
  int active = 0;
  logic [9:0] exp_q[$];
  logic [9:0] e;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_stream_arb #(.N(4), .WIDTH(8), .MODE(g)) u_dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(ir[g]),
`ifdef MUX_STREAM_LOCK_EN
      .in_last(in_last),
`endif
      .sel(sel),
      .out_data(od[g]),
      .out_sel(os[g]),
      .out_valid(ov[g]),
      .out_ready(out_ready)
    );
  end

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", n, a, x);
    end
  endtask

  task automatic push(input logic [1:0] s);
    exp_q.push_back({s, 8'hA0 + {6'd0, s}});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    in_valid = 4'h0;
    out_ready = 1'b1;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_n && ov[active] && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h required none", {os[active], od[active]});
      end else begin
        e = exp_q.pop_front();
        check("out_word", {22'd0, os[active], od[active]}, {22'd0, e});
      end
    end
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        check("rst_valid", ov[m], 0);
        check("rst_data", od[m], 0);
        check("rst_ready", ir[m], 0);
      end
    end
    tick;
    reset_n = 1'b1;
    active = 0;
    push(0); push(1); push(2); push(3); push(0);
    repeat (5) tick;
    in_valid = 4'h0;
    tick;
    check("rr_drain", ov[0], 0);

    do_reset;
    push(0); push(1);
    in_valid = 4'hF;
    tick;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_data", od[0], 8'hA0);
      check("stall_valid", ov[0], 1);
      check("stall_ready", ir[0], 0);
      tick;
    end
    out_ready = 1'b1;
    tick;
    in_valid = 4'h0;
    tick;

    do_reset;
    active = 1;
    in_valid = 4'b1010;
    repeat (4) begin
      push(1);
      @(negedge clk);
      check("prio_ready", ir[1], 4'b0010);
      tick;
    end
    in_valid = 4'h0;
    tick;

    do_reset;
    active = 2;
    sel = 2'd3;
    in_valid = 4'hF;
    push(3);
    tick;
    in_valid = 4'b0111;
    tick;
    check("ext_nosel_valid", ov[2], 0);
    check("ext_nosel_hold", od[2], 8'hA3);
    check("ext_nosel_ready", ir[2], 0);
    sel = 2'd1;
    in_valid = 4'hF;
    push(1);
    tick;
    in_valid = 4'h0;
    tick;

    do_reset;
    active = 0;
    in_valid = 4'hF;
    out_ready = 1'b0;
    tick;
    check("pre_rst_valid", ov[0], 1);
    reset_n = 1'b0;
    in_valid = 4'h0;
    tick;
    check("rst_stall_valid", ov[0], 0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 4'hF;
    push(0);
    tick;
    in_valid = 4'h0;
    tick;

`ifdef MUX_STREAM_LOCK_EN
    do_reset;
    active = 0;
    in_valid = 4'b0100;
    push(2); push(2); push(2); push(0);
    tick;
    in_valid = 4'b0111;
    tick;
    in_last = 4'b0100;
    tick;
    in_last = 4'h0;
    tick;
    in_valid = 4'h0;
    tick;
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
